// File: rtl/decouple_rr_arbiter_if.sv
// rtl/decouple_rr_arbiter_if.sv - Producer and consumer handshake bundle for decouple_rr_arbiter
interface decouple_rr_arbiter_if #(
  parameter int NUM = 4,
  parameter int DIN = 16
);
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;

  logic [NUM*DIN-1:0] din_data;
  logic [NUM-1:0]     din_valid;
  logic [NUM-1:0]     din_ready;
  logic [DIN-1:0]     dout_data;
  logic [IDXW-1:0]    dout_idx;
  logic               dout_valid;
  logic               dout_ready;

  modport master (
    output din_data, din_valid, dout_ready,
    input  din_ready, dout_data, dout_idx, dout_valid
  );

  modport slave (
    input  din_data, din_valid, dout_ready,
    output din_ready, dout_data, dout_idx, dout_valid
  );
endinterface

// File: rtl/decouple_rr_arbiter.sv
// rtl/decouple_rr_arbiter.sv - Round-robin arbiter with registered output stage; packet lock under DECOUPLE_ARB_LOCK_EN
module decouple_rr_arbiter #(
  parameter int NUM = 4,
  parameter int DIN = 16
) (
  input logic                 clk,
  input logic                 rst,
  decouple_rr_arbiter_if.slave bus
);
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;

  logic [IDXW-1:0] ptr;
  logic [NUM-1:0]  elig;
  logic [NUM-1:0]  req;
  logic [NUM-1:0]  req_rot;
  logic [IDXW-1:0] rot_pos;
  logic [IDXW:0]   gnt_sum;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;
  logic [DIN-1:0]  gnt_data;
  logic [NUM-1:0]  din_ready_c;
  logic            load;
  logic            xfer;
  logic            adv_ptr;

  logic            dout_valid_q;
  logic [DIN-1:0]  dout_data_q;
  logic [IDXW-1:0] dout_idx_q;

  assign load = ~dout_valid_q | bus.dout_ready;
  assign req  = bus.din_valid & elig;

  // Rotate requests so bit 0 is the input at ptr; lowest set bit wins.
  assign req_rot = NUM'({req, req} >> ptr);

  always_comb begin
    rot_pos = '0;
    gnt_any = 1'b0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_pos = IDXW'(i);
        gnt_any = 1'b1;
      end
    end
  end

  assign gnt_sum = {1'b0, ptr} + {1'b0, rot_pos};
  assign gnt_idx = (gnt_sum >= (IDXW+1)'(NUM)) ? IDXW'(gnt_sum - (IDXW+1)'(NUM))
                                               : IDXW'(gnt_sum);

  always_comb begin
    gnt_data    = '0;
    din_ready_c = '0;
    for (int i = 0; i < NUM; i++) begin
      if (gnt_idx == IDXW'(i)) begin
        gnt_data       = bus.din_data[i*DIN +: DIN];
        din_ready_c[i] = rst & load & gnt_any;
      end
    end
  end

  assign bus.din_ready = din_ready_c;
  assign xfer          = load & gnt_any;

`ifdef DECOUPLE_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} lock_state_t;

  lock_state_t     state, state_nxt;
  logic [IDXW-1:0] lock_idx, lock_idx_nxt;
  logic            eot;

  assign eot = gnt_data[DIN-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    if (xfer) begin
      if (state == IDLE && !eot) begin
        state_nxt    = LOCKED;
        lock_idx_nxt = gnt_idx;
      end else if (state == LOCKED && eot) begin
        state_nxt = IDLE;
      end
    end
  end

  // While locked only the packet owner is eligible, even if it is idle.
  always_comb begin
    elig = '1;
    if (state == LOCKED) begin
      for (int i = 0; i < NUM; i++) elig[i] = (lock_idx == IDXW'(i));
    end
  end

  assign adv_ptr = xfer & eot;
`else
  assign elig    = '1;
  assign adv_ptr = xfer;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_idx_q   <= '0;
      ptr          <= '0;
    end else begin
      if (load) begin
        dout_valid_q <= gnt_any;
        if (gnt_any) begin
          dout_data_q <= gnt_data;
          dout_idx_q  <= gnt_idx;
        end
      end
      if (adv_ptr) ptr <= (gnt_idx == IDXW'(NUM - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_data  = dout_data_q;
  assign bus.dout_idx   = dout_idx_q;
endmodule

// File: tb/tb_decouple_rr_arbiter.sv
// tb/tb_decouple_rr_arbiter.sv - Directed self-checking bench for decouple_rr_arbiter
module tb_decouple_rr_arbiter;
  localparam int NUM = 4;
  localparam int DIN = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  decouple_rr_arbiter_if #(.NUM(NUM), .DIN(DIN)) bus ();

  decouple_rr_arbiter #(.NUM(NUM), .DIN(DIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.dout_ready = 1'b1;
    bus.din_valid  = 4'hF;
    bus.din_data   = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    rst = 1'b0;
    cyc();
    cyc();
    check("rst_din_ready", 32'(bus.din_ready), 'h0);
    check("rst_dout_valid", 32'(bus.dout_valid), 'h0);
    check("rst_dout_idx", 32'(bus.dout_idx), 'h0);
    check("rst_dout_data", 32'(bus.dout_data), 'h0);

`ifdef DECOUPLE_ARB_LOCK_EN
    bus.din_data  = {16'h0000, 16'h8022, 16'h0011, 16'h8000};
    bus.din_valid = 4'b0010;
    rst = 1'b1;
    #1;
    check("lock_first_ready", 32'(bus.din_ready), 'h2);
    cyc();
    check("lock_w0_idx", 32'(bus.dout_idx), 'h1);
    check("lock_w0_data", 32'(bus.dout_data), 'h0011);
    bus.din_valid = 4'b0101;
    #1;
    check("lock_owner_idle_ready", 32'(bus.din_ready), 'h0);
    cyc();
    check("lock_gap_valid", 32'(bus.dout_valid), 'h0);
    bus.din_data[16 +: 16] = 16'h0012;
    bus.din_valid = 4'b0111;
    #1;
    check("lock_w1_ready", 32'(bus.din_ready), 'h2);
    cyc();
    check("lock_w1_idx", 32'(bus.dout_idx), 'h1);
    check("lock_w1_data", 32'(bus.dout_data), 'h0012);
    bus.din_data[16 +: 16] = 16'h8013;
    #1;
    check("lock_w2_ready", 32'(bus.din_ready), 'h2);
    cyc();
    check("lock_w2_idx", 32'(bus.dout_idx), 'h1);
    check("lock_w2_data", 32'(bus.dout_data), 'h8013);
    bus.din_valid = 4'b0101;
    #1;
    check("unlock_ready", 32'(bus.din_ready), 'h4);
    cyc();
    check("unlock_idx2", 32'(bus.dout_idx), 'h2);
    check("unlock_data2", 32'(bus.dout_data), 'h8022);
    bus.din_valid = 4'b0001;
    #1;
    check("after_ready", 32'(bus.din_ready), 'h1);
    cyc();
    check("after_idx0", 32'(bus.dout_idx), 'h0);
    check("after_data0", 32'(bus.dout_data), 'h8000);
`else
    rst = 1'b1;
    #1;
    check("release_ready", 32'(bus.din_ready), 'h1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      check("fair_valid", 32'(bus.dout_valid), 'h1);
      check("fair_idx", 32'(bus.dout_idx), k % 4);
      check("fair_data", 32'(bus.dout_data), 'hA0 + (k % 4));
      check("fair_ready", 32'(bus.din_ready), 1 << ((k + 1) % 4));
    end

    bus.dout_ready = 1'b0;
    #1;
    check("bp_din_ready", 32'(bus.din_ready), 'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("bp_valid", 32'(bus.dout_valid), 'h1);
      check("bp_idx", 32'(bus.dout_idx), 'h3);
      check("bp_data", 32'(bus.dout_data), 'hA3);
      check("bp_ready", 32'(bus.din_ready), 'h0);
    end
    bus.dout_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.din_ready), 'h1);
    cyc();
    check("bp_next_idx", 32'(bus.dout_idx), 'h0);

    bus.din_valid = 4'b0100;
    #1;
    check("skip_ready2", 32'(bus.din_ready), 'h4);
    cyc();
    check("skip_idx2", 32'(bus.dout_idx), 'h2);
    bus.din_valid = 4'b0101;
    #1;
    check("wrap_ready0", 32'(bus.din_ready), 'h1);
    cyc();
    check("wrap_idx0", 32'(bus.dout_idx), 'h0);
    check("wrap_ready2", 32'(bus.din_ready), 'h4);
    cyc();
    check("wrap_idx2", 32'(bus.dout_idx), 'h2);

    bus.din_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(bus.din_ready), 'h0);
    cyc();
    check("idle_valid", 32'(bus.dout_valid), 'h0);

    bus.din_valid = 4'b0010;
    #1;
    check("pre_rst_ready", 32'(bus.din_ready), 'h2);
    cyc();
    check("pre_rst_valid", 32'(bus.dout_valid), 'h1);
    check("pre_rst_idx", 32'(bus.dout_idx), 'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.dout_valid), 'h0);
    check("async_rst_idx", 32'(bus.dout_idx), 'h0);
    check("async_rst_ready", 32'(bus.din_ready), 'h0);
    cyc();
    rst = 1'b1;
    bus.din_valid = 4'hF;
    #1;
    check("restart_ready0", 32'(bus.din_ready), 'h1);
    bus.din_valid = 4'b1000;
    #1;
    check("only3_ready", 32'(bus.din_ready), 'h8);
    cyc();
    check("only3_idx", 32'(bus.dout_idx), 'h3);
    check("only3_data", 32'(bus.dout_data), 'hA3);
    bus.din_valid = 4'hF;
    #1;
    check("ptr_wrap_ready", 32'(bus.din_ready), 'h1);
    cyc();
    check("ptr_wrap_idx", 32'(bus.dout_idx), 'h0);
    check("ptr_wrap_data", 32'(bus.dout_data), 'hA0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
